video_pattern_gen: RTL

Synthesizable video stream source that produces the pixel-clock stream consumed by the vision blocks: `de`, `hsync`, `vsync` and 24-bit RGB pixels. Timing is set by parameters, and the content is a selectable test pattern. It is the transmitting end of the same stream interface the vision blocks receive. It replaces file-driven stimulus on hardware and drives the pipeline input in bring-up builds.

---
 rtl/video_timing_pkg.sv | 39 +++
 rtl/video_timing_core.sv | 64 ++++++
 rtl/video_pattern_gen.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared definitions for the test-pattern video source: pattern codes,
// colour-bar palette and the line/frame total helper.
package video_timing_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_RAMP  = 2'd3
    } pattern_e;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return COL_WHITE;
            3'd1:    return COL_YELLOW;
            3'd2:    return COL_CYAN;
            3'd3:    return COL_GREEN;
            3'd4:    return COL_MAGENTA;
            3'd5:    return COL_RED;
            3'd6:    return COL_BLUE;
            default: return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_timing_core.sv
// Horizontal/vertical raster counters with active, sync and frame-wrap decode.
// Decode is combinational from the counter registers; the top registers it.
module video_timing_core
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = 64,
    parameter int H_FP     = 4,
    parameter int H_SYNC   = 8,
    parameter int H_BP     = 4,
    parameter int V_ACTIVE = 48,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 2,
    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int H_W     = $clog2(H_TOTAL),
    localparam int V_W     = $clog2(V_TOTAL)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output logic           active,
    output logic           hs_active,
    output logic           vs_active,
    output logic           at_origin,
    output logic           frame_wrap
);

    logic [H_W-1:0] h_cnt_reg;
    logic [V_W-1:0] v_cnt_reg;
    int             h_pos;
    int             v_pos;
    logic           h_last;
    logic           v_last;

    assign h_pos  = int'(h_cnt_reg);
    assign v_pos  = int'(v_cnt_reg);
    assign h_last = (h_pos == H_TOTAL - 1);
    assign v_last = (v_pos == V_TOTAL - 1);

    // Dropping en aborts the frame outright; the next run always starts at (0,0).
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_last) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= v_last ? '0 : v_cnt_reg + V_W'(1);
        end else begin
            h_cnt_reg <= h_cnt_reg + H_W'(1);
        end
    end

    assign h_cnt      = h_cnt_reg;
    assign v_cnt      = v_cnt_reg;
    assign active     = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
    assign hs_active  = (h_pos >= H_ACTIVE + H_FP) && (h_pos < H_ACTIVE + H_FP + H_SYNC);
    assign vs_active  = (v_pos >= V_ACTIVE + V_FP) && (v_pos < V_ACTIVE + V_FP + V_SYNC);
    assign at_origin  = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    assign frame_wrap = h_last && v_last;

endmodule

// File: rtl/video_pattern_gen.sv
// Parameterised video source: raster timing plus a selectable test pattern,
// with every output registered one cycle after the counter state.
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = 64,
    parameter int H_FP     = 4,
    parameter int H_SYNC   = 8,
    parameter int H_BP     = 4,
    parameter int V_ACTIVE = 48,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 2,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [23:0] pixel,
    output logic        frame_start
);

    localparam int   H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int   V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int   H_W     = $clog2(H_TOTAL);
    localparam int   V_W     = $clog2(V_TOTAL);
    localparam logic HS_ON   = 1'(HS_POL);
    localparam logic VS_ON   = 1'(VS_POL);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           active;
    logic           hs_active;
    logic           vs_active;
    logic           at_origin;
    logic           frame_wrap;

    video_timing_core #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .active     (active),
        .hs_active  (hs_active),
        .vs_active  (vs_active),
        .at_origin  (at_origin),
        .frame_wrap (frame_wrap)
    );

    logic [7:0]  fcnt_reg;
    pattern_e    pattern_reg;
    logic [23:0] solid_reg;
    pattern_e    pattern_cur;
    logic [23:0] solid_cur;

    // Selection is captured at (0,0); that same pixel already uses the live inputs.
    assign pattern_cur = at_origin ? pattern_e'(pattern_sel) : pattern_reg;
    assign solid_cur   = at_origin ? solid_rgb : solid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_reg    <= '0;
            pattern_reg <= PAT_SOLID;
            solid_reg   <= '0;
        end else if (en) begin
            if (frame_wrap)
                fcnt_reg <= fcnt_reg + 8'd1;
            if (at_origin) begin
                pattern_reg <= pattern_e'(pattern_sel);
                solid_reg   <= solid_rgb;
            end
        end
    end

    logic [7:0] x8;
    logic [7:0] y8;

    generate
        if (H_W >= 8) begin : g_x_trunc
            assign x8 = h_cnt[7:0];
        end else begin : g_x_ext
            assign x8 = {{(8-H_W){1'b0}}, h_cnt};
        end
        if (V_W >= 8) begin : g_y_trunc
            assign y8 = v_cnt[7:0];
        end else begin : g_y_ext
            assign y8 = {{(8-V_W){1'b0}}, v_cnt};
        end
    endgenerate

    // Bar g starts at the first x with x*8 >= g*H_ACTIVE, i.e. ceil(g*H_ACTIVE/8).
    int         h_pos;
    logic [7:1] bar_ge;
    logic [2:0] bar_idx;

    assign h_pos = int'(h_cnt);

    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_bar_thr
            localparam int THR = (gi * H_ACTIVE + 7) / 8;
            assign bar_ge[gi] = (h_pos >= THR);
        end
    endgenerate

    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (bar_ge[i])
                bar_idx = 3'(i);
        end
    end

    logic [23:0] pixel_next;

    always_comb begin
        pixel_next = '0;
        case (pattern_cur)
            PAT_SOLID: pixel_next = solid_cur;
            PAT_BARS:  pixel_next = bar_colour(bar_idx);
            PAT_GRAD:  pixel_next = {x8, y8, x8 ^ y8};
            PAT_RAMP:  pixel_next = {x8 + fcnt_reg, y8 + fcnt_reg, fcnt_reg};
            default:   pixel_next = '0;
        endcase
    end

    logic        de_reg;
    logic        hsync_reg;
    logic        vsync_reg;
    logic [23:0] pixel_reg;
    logic        frame_start_reg;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            de_reg          <= 1'b0;
            hsync_reg       <= ~HS_ON;
            vsync_reg       <= ~VS_ON;
            pixel_reg       <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            de_reg          <= active;
            hsync_reg       <= hs_active ? HS_ON : ~HS_ON;
            vsync_reg       <= vs_active ? VS_ON : ~VS_ON;
            pixel_reg       <= active ? pixel_next : 24'h0;
            frame_start_reg <= at_origin;
        end
    end

    assign de          = de_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign pixel       = pixel_reg;
    assign frame_start = frame_start_reg;

endmodule
